// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the comparator flag sanity check.
package sar_search_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRIAL = 1'b1
  } state_t;

  // The comparator must report exactly one relation; anything else means the
  // flags are broken and the search cannot be trusted.
  function automatic logic flags_legal(input logic gt, input logic lt, input logic eq);
    return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search.sv
// MSB-first binary search around a magnitude comparator. Each trial value is
// held for SETTLE cycles, the flags are sampled once at the end of that window,
// and the recovered value is reported with a one-cycle done pulse.
//
//  state   | meaning
//  S_IDLE  | waiting for start; result/trials/err hold the last search
//  S_TRIAL | y_out driven with the current candidate, settling then sampling
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       xgy,
  input  logic                       xsy,
  input  logic                       xey,
  output logic [WIDTH-1:0]           y_out,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] trials,
  output logic                       err
);

  localparam int TW  = $clog2(WIDTH + 1);
  localparam int KW  = $clog2(WIDTH);
  localparam int SCW = 4;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] y, y_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [SCW-1:0]   sc, sc_nxt;
  logic [WIDTH-1:0] res, res_nxt;
  logic [TW-1:0]    tr, tr_nxt;
  logic             err_q, err_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [WIDTH-1:0] cand;
  logic             sample;

  assign sample = (sc == SCW'(SETTLE - 1));

  // Next-state and datapath decisions; everything holds unless a branch says otherwise.
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    k_nxt     = k;
    sc_nxt    = sc;
    res_nxt   = res;
    tr_nxt    = tr;
    err_nxt   = err_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    cand      = y;
    case (state)
      S_IDLE: begin
        if (start) begin
          y_nxt     = WIDTH'(1) << (WIDTH - 1);
          k_nxt     = KW'(WIDTH - 1);
          sc_nxt    = '0;
          tr_nxt    = '0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_TRIAL;
        end
      end
      S_TRIAL: begin
        if (!sample) begin
          sc_nxt = sc + SCW'(1);
        end else begin
          tr_nxt = tr + TW'(1);
          if (!flags_legal(xgy, xsy, xey)) begin
            err_nxt   = 1'b1;
            res_nxt   = '0;
            y_nxt     = '0;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else if (xey) begin
            res_nxt   = y;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            // x below the trial: this bit overshoots, drop it; x above: keep it.
            if (xsy) cand[k] = 1'b0;
            if (k == '0) begin
              res_nxt   = cand;
              y_nxt     = cand;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = S_IDLE;
            end else begin
              cand[k - KW'(1)] = 1'b1;
              y_nxt  = cand;
              k_nxt  = k - KW'(1);
              sc_nxt = '0;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Register all controller state; reset wins over any search in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      y      <= '0;
      k      <= '0;
      sc     <= '0;
      res    <= '0;
      tr     <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      y      <= y_nxt;
      k      <= k_nxt;
      sc     <= sc_nxt;
      res    <= res_nxt;
      tr     <= tr_nxt;
      err_q  <= err_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign y_out  = y;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res;
  assign trials = tr;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: two instances (SETTLE=1 and SETTLE=3) each wrapped
// around a 4-bit comparator, checked every cycle against an interval-halving
// model, plus directed searches with literal expectations.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s[2];
  logic [3:0] xval[2];
  logic       force_bad[2];

  logic [3:0] y_o[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic [3:0] res_o[2];
  logic [2:0] tr_o[2];
  logic       err_o[2];
  logic       gt_f[2];
  logic       lt_f[2];
  logic       eq_f[2];

  int total = 0;
  int bad   = 0;

  // model state
  int m_y[2], m_lo[2], m_step[2], m_t[2], m_tr[2], m_res[2];
  bit m_act[2], m_busy[2], m_done[2], m_err[2];
  int m_s;
  bit m_gt, m_lt, m_eq;

  always #5 clk = ~clk;

  // Comparator around each instance; force_bad makes it report x>y and x<y at once.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      gt_f[d] = force_bad[d] | (xval[d] > y_o[d]);
      lt_f[d] = force_bad[d] | (xval[d] < y_o[d]);
      eq_f[d] = !force_bad[d] && (xval[d] == y_o[d]);
    end
  end

  sar_search #(.WIDTH(4), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .xgy(gt_f[0]), .xsy(lt_f[0]), .xey(eq_f[0]),
    .y_out(y_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .result(res_o[0]), .trials(tr_o[0]), .err(err_o[0])
  );

  sar_search #(.WIDTH(4), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .xgy(gt_f[1]), .xsy(lt_f[1]), .xey(eq_f[1]),
    .y_out(y_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .result(res_o[1]), .trials(tr_o[1]), .err(err_o[1])
  );

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: the search is an interval [lo, lo+2*step) probed at lo+step.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_s = (d == 0) ? 1 : 3;
      m_done[d] = 1'b0;
      if (rst) begin
        m_y[d] = 0; m_busy[d] = 0; m_res[d] = 0; m_tr[d] = 0; m_err[d] = 0; m_act[d] = 0;
      end else if (!m_act[d]) begin
        if (start_s[d]) begin
          m_act[d] = 1; m_busy[d] = 1; m_lo[d] = 0; m_step[d] = 8; m_y[d] = 8;
          m_t[d] = 0; m_tr[d] = 0; m_err[d] = 0;
        end
      end else if (m_t[d] != m_s - 1) begin
        m_t[d]++;
      end else begin
        m_tr[d]++;
        m_gt = force_bad[d] || (int'(xval[d]) > m_y[d]);
        m_lt = force_bad[d] || (int'(xval[d]) < m_y[d]);
        m_eq = !force_bad[d] && (int'(xval[d]) == m_y[d]);
        if (int'(m_gt) + int'(m_lt) + int'(m_eq) != 1) begin
          m_err[d] = 1; m_res[d] = 0; m_y[d] = 0;
          m_done[d] = 1; m_busy[d] = 0; m_act[d] = 0;
        end else if (m_eq) begin
          m_res[d] = m_y[d];
          m_done[d] = 1; m_busy[d] = 0; m_act[d] = 0;
        end else begin
          if (m_gt) m_lo[d] = m_y[d];
          m_step[d] = m_step[d] / 2;
          if (m_step[d] == 0) begin
            m_res[d] = m_lo[d]; m_y[d] = m_lo[d];
            m_done[d] = 1; m_busy[d] = 0; m_act[d] = 0;
          end else begin
            m_y[d] = m_lo[d] + m_step[d];
            m_t[d] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("y_out",  d, 64'(y_o[d]),   64'(m_y[d]));
      chk("busy",   d, 64'(busy_o[d]), 64'(m_busy[d]));
      chk("done",   d, 64'(done_o[d]), 64'(m_done[d]));
      chk("result", d, 64'(res_o[d]), 64'(m_res[d]));
      chk("trials", d, 64'(tr_o[d]),  64'(m_tr[d]));
      chk("err",    d, 64'(err_o[d]), 64'(m_err[d]));
    end
  end

  // Start a search at the current negedge, follow it to done, check literals.
  task automatic run(input int d, input logic [3:0] xv, input logic [3:0] er, input int et,
                     input int ecyc, input logic [63:0] eseq, input int hold);
    int n;
    logic [63:0] seq;
    xval[d] = xv;
    start_s[d] = 1'b1;
    @(negedge clk);
    n = 0;
    seq = '0;
    while (!done_o[d] && n < 200) begin
      if (n >= hold) start_s[d] = 1'b0;
      if (busy_o[d]) seq = {seq[59:0], y_o[d]};
      @(negedge clk);
      n++;
    end
    start_s[d] = 1'b0;
    chk("run_cycles", d, 64'(n), 64'(ecyc));
    chk("run_result", d, 64'(res_o[d]), 64'(er));
    chk("run_trials", d, 64'(tr_o[d]), 64'(et));
    chk("run_err",    d, 64'(err_o[d]), 64'd0);
    chk("run_seq",    d, seq, eseq);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; xval[d] = 4'd0; force_bad[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_y",    d, 64'(y_o[d]), 64'd0);
      chk("rst_busy", d, 64'(busy_o[d]), 64'd0);
      chk("rst_res",  d, 64'(res_o[d]), 64'd0);
      chk("rst_tr",   d, 64'(tr_o[d]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run(0, 4'd8,  4'd8,  1, 1, 64'h8,    0);
    run(0, 4'd7,  4'd7,  4, 4, 64'h8467, 0);
    run(0, 4'd0,  4'd0,  4, 4, 64'h8421, 0);
    run(0, 4'd15, 4'd15, 4, 4, 64'h8cef, 0);
    run(1, 4'd5,  4'd5,  4, 12, 64'h888444666555, 0);
    run(1, 4'd5,  4'd5,  4, 12, 64'h888444666555, 5);

    // invalid flags at the second sample
    @(negedge clk);
    xval[0] = 4'd9;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    force_bad[0] = 1'b1;
    @(negedge clk);
    chk("bad_done", 0, 64'(done_o[0]), 64'd1);
    chk("bad_err",  0, 64'(err_o[0]), 64'd1);
    chk("bad_res",  0, 64'(res_o[0]), 64'd0);
    chk("bad_y",    0, 64'(y_o[0]), 64'd0);
    chk("bad_busy", 0, 64'(busy_o[0]), 64'd0);
    chk("bad_tr",   0, 64'(tr_o[0]), 64'd2);
    force_bad[0] = 1'b0;
    run(0, 4'd9, 4'd9, 4, 4, 64'h8ca9, 0);

    // reset in the middle of a search, with start also high
    @(negedge clk);
    xval[0] = 4'd7;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_y",    0, 64'(y_o[0]), 64'd0);
    chk("mid_rst_busy", 0, 64'(busy_o[0]), 64'd0);
    chk("mid_rst_tr",   0, 64'(tr_o[0]), 64'd0);
    rst = 1'b0;
    start_s[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 0, 64'(busy_o[0]), 64'd0);
    run(0, 4'd3, 4'd3, 4, 4, 64'h8423, 0);

    // back-to-back: start held across the done cycle
    @(negedge clk);
    xval[0] = 4'd8;
    start_s[0] = 1'b1;
    @(negedge clk);
    chk("b2b_busy1", 0, 64'(busy_o[0]), 64'd1);
    @(negedge clk);
    chk("b2b_done1", 0, 64'(done_o[0]), 64'd1);
    @(negedge clk);
    chk("b2b_busy2", 0, 64'(busy_o[0]), 64'd1);
    chk("b2b_y2",    0, 64'(y_o[0]), 64'd8);
    start_s[0] = 1'b0;
    @(negedge clk);
    chk("b2b_done2", 0, 64'(done_o[0]), 64'd1);
    @(negedge clk);
    chk("b2b_idle",  0, 64'(busy_o[0] | done_o[0]), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
